// File: rtl/lfsr_share_ctrl.sv
// Round-robin sequencer sharing one 8-bit LFSR between two requesters:
// optional reseed, N step pulses, then return the LFSR byte to the winner.
module lfsr_share_ctrl #(
  parameter int          STEP_W       = 4,
  parameter logic [7:0]  DEFAULT_SEED = 8'hA5
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [1:0]          req_i,
  input  logic [1:0]          seed_load_i,
  input  logic [15:0]         seed_i,
  input  logic [2*STEP_W-1:0] steps_i,
  output logic                lfsr_load_o,
  output logic [7:0]          lfsr_seed_o,
  output logic                lfsr_step_o,
  input  logic [7:0]          lfsr_value_i,
  output logic [1:0]          ack_o,
  output logic [7:0]          data_o,
  output logic                done_o,
  output logic                owner_o,
  output logic                busy_o
);

  typedef enum logic [2:0] {INIT, IDLE, LOAD, STEP, CAPTURE} state_t;

  localparam logic [STEP_W-1:0] CNT_ONE = 1;

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   cnt_q, cnt_d;
  logic                last_owner_q;
  logic                grant;
  logic                win;
  logic                sel_load;
  logic [7:0]          sel_seed;
  logic [STEP_W-1:0]   sel_steps;

  // An all-zero seed would lock the LFSR up, so it is replaced.
  function automatic logic [7:0] fix_seed(input logic [7:0] s);
    return (s == 8'h00) ? DEFAULT_SEED : s;
  endfunction

  always_comb begin
    win       = (&req_i) ? ~last_owner_q : req_i[1];
    sel_load  = seed_load_i[win];
    sel_seed  = win ? seed_i[15:8] : seed_i[7:0];
    sel_steps = win ? steps_i[2*STEP_W-1:STEP_W] : steps_i[STEP_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant   = 1'b0;
    case (state_q)
      // INIT holds for the cycle in which the registered load pulse is visible.
      INIT:    state_d = lfsr_load_o ? IDLE : INIT;
      IDLE: begin
        if (|req_i) begin
          grant = 1'b1;
          cnt_d = sel_steps;
          if (sel_load)                 state_d = LOAD;
          else if (sel_steps != '0)     state_d = STEP;
          else                          state_d = CAPTURE;
        end
      end
      LOAD:    state_d = (cnt_q != '0) ? STEP : CAPTURE;
      STEP: begin
        if (cnt_q <= CNT_ONE) state_d = CAPTURE;
        else                  cnt_d   = cnt_q - CNT_ONE;
      end
      CAPTURE: state_d = IDLE;
      default: state_d = INIT;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= INIT;
      cnt_q        <= '0;
      last_owner_q <= 1'b1;
      owner_o      <= 1'b0;
      lfsr_load_o  <= 1'b0;
      lfsr_step_o  <= 1'b0;
      lfsr_seed_o  <= DEFAULT_SEED;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      ack_o        <= 2'b00;
      data_o       <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lfsr_load_o <= (state_d == INIT) || (state_d == LOAD);
      lfsr_step_o <= (state_d == STEP);
      lfsr_seed_o <= (grant && sel_load) ? fix_seed(sel_seed) : DEFAULT_SEED;
      busy_o      <= (state_d != IDLE);
      done_o      <= (state_q == CAPTURE);
      ack_o       <= (state_q == CAPTURE) ? (owner_o ? 2'b10 : 2'b01) : 2'b00;
      if (state_q == CAPTURE) data_o <= lfsr_value_i;
      if (grant) begin
        owner_o      <= win;
        last_owner_q <= win;
      end
    end
  end

endmodule

// File: doc/lfsr_share_ctrl.md
Name: lfsr_share_ctrl

Overview:
- Sequencer and round-robin arbiter that shares one 8-bit LFSR between two requesters.
- Drives the LFSR's synchronous load (active-high), seed value and step-enable inputs, and reads back its register value.
- Each transaction optionally reseeds the LFSR, steps it N times, then returns the resulting byte to the winning requester.

Parameters:
- STEP_W, 4: width of each requester's step-count field (max steps 2^STEP_W-1).
- DEFAULT_SEED, 8'hA5: seed loaded after reset, and substituted for any requested seed of 8'h00 (all-zero is a lock-up state).

Ports:
- clk_i  in  1  system clock, all logic on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- req_i  in  2  per-requester request; held high until that requester's ack_o bit pulses.
- seed_load_i  in  2  per-requester: reseed before stepping.
- seed_i  in  16  per-requester seed, requester k at [8k+7:8k].
- steps_i  in  2*STEP_W  per-requester step count, requester k at [STEP_W*k+STEP_W-1:STEP_W*k].
- lfsr_load_o  out  1  to LFSR synchronous load.
- lfsr_seed_o  out  8  to LFSR seed value.
- lfsr_step_o  out  1  to LFSR step enable.
- lfsr_value_i  in  8  LFSR register value.
- ack_o  out  2  one-cycle completion pulse to the owning requester.
- data_o  out  8  result byte, held until the next completion.
- done_o  out  1  one-cycle pulse, coincident with the ack_o bit.
- owner_o  out  1  index of the current/last granted requester.
- busy_o  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst_i=0, async) clears all outputs to 0 except lfsr_seed_o=DEFAULT_SEED. Internal round-robin pointer last_owner=1. FSM enters INIT.
- FSM states: INIT, IDLE, LOAD, STEP, CAPTURE.
- INIT: lfsr_load_o=1 and lfsr_seed_o=DEFAULT_SEED for exactly one cycle, then go to IDLE.
- IDLE: if any req_i bit is set, grant one requester.
  - Both set: grant the bit != last_owner.
  - One set: grant it.
  - On grant, register owner_o and last_owner, and latch that requester's seed_load, seed and steps.
  - Next state: LOAD if seed_load; otherwise STEP if steps != 0; otherwise CAPTURE.
- LOAD: one cycle with lfsr_load_o=1 and lfsr_seed_o=latched seed (DEFAULT_SEED if the latched seed is 0). Next state: STEP if steps != 0, else CAPTURE.
- STEP: lfsr_step_o=1 for exactly `steps` consecutive cycles, using an internal down-counter. Then go to CAPTURE.
- CAPTURE: on the exiting edge, data_o<=lfsr_value_i, done_o<=1 and ack_o[owner]<=1 (each registered, high for one cycle). Next state: IDLE.
- Outputs are registered, and lfsr_load_o/lfsr_step_o are decoded from state so they align with their state's cycle.
- Latency from the IDLE edge that grants to the done_o pulse:
  - steps+2 cycles without seed.
  - steps+3 cycles with seed.
  - steps=0 without seed: 2 cycles, returns the current value unchanged.
- IDLE may grant a new request in the same cycle done_o is high. The just-acked requester loses priority on a tie.
- Requests are never preempted. Dropping req_i mid-transaction does not abort it: the transaction completes and ack_o still pulses.
- req_i changes while busy_o=1 are ignored until IDLE.
- seed_i/steps_i are sampled only at grant.
- lfsr_load_o and lfsr_step_o are never high together.
- Reset mid-transaction: immediate abort, no ack, then INIT reseeds DEFAULT_SEED.

Test Plan:
- Release reset, no requests -> lfsr_load_o=1 with lfsr_seed_o=8'hA5 for one cycle, then busy_o=0. LFSR holds 8'hA5.
- Req0, seed_load=1, seed=8'h01, steps=3 -> one LOAD cycle, 3 STEP cycles. done_o, ack_o=2'b01 and data_o=8'h0D exactly 6 cycles after grant.
- Req1, no seed, steps=1, after reset -> data_o=8'h4A, ack_o=2'b10, owner_o=1, 3 cycles after grant.
- req_i=2'b11 held continuously, steps=0, no seed -> grants alternate 0,1,0,1. Each ack arrives 2 cycles after its grant, with back-to-back grants.
- Req0 with seed 8'h00, steps=1 -> LOAD drives 8'hA5; data_o=8'h4A.
- Assert rst_i=0 during STEP of a 10-step request -> outputs clear immediately, no ack. After release: INIT load of 8'hA5, then the still-high request is regranted and completes normally.
